// File: rtl/hsci_pkg.sv
// Shared types for the HSCI read-buffer arbiter: bus widths, arbiter state
// encodings and the write-FIFO entry layout.
package hsci_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int WE_W   = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [WE_W-1:0]   we_t;

   // The encodings are exported unchanged on arb_fsm for the status register.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_WR    = 2'd1,
      ARB_RD    = 2'd2,
      ARB_FORCE = 2'd3
   } arb_state_e;

   typedef struct packed {
      we_t   we;
      addr_t addr;
      data_t data;
   } wfifo_entry_t;

endpackage

// File: rtl/hsci_rdbuf_arb_if.sv
// Decoder write port, host read port and RAM command port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface hsci_rdbuf_arb_if;
   import hsci_pkg::*;

   logic  dec_en;
   we_t   dec_we;
   addr_t dec_addr;
   data_t dec_data;

   logic  host_req;
   addr_t host_addr;
   logic  host_gnt;
   logic  host_rvalid;
   data_t host_rdata;

   logic  ram_en;
   we_t   ram_we;
   addr_t ram_addr;
   data_t ram_wdata;
   data_t ram_rdata;

   modport slave (
      input  dec_en, dec_we, dec_addr, dec_data, host_req, host_addr, ram_rdata,
      output host_gnt, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output dec_en, dec_we, dec_addr, dec_data, host_req, host_addr, ram_rdata,
      input  host_gnt, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/hsci_arb_wfifo.sv
// Synchronous write FIFO with registered full/empty and occupancy count.
// When empty, rd_data falls through from wr_data so a same-cycle push+pop bypasses storage.
module hsci_arb_wfifo
   import hsci_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  wfifo_entry_t wr_data,
   output wfifo_entry_t rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wfifo_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          adv, store;

   always_comb begin
      adv      = pop && !empty_q;
      // A push into a full FIFO only lands if a pop frees a slot the same cycle.
      store    = push && (!full_q || adv) && !(empty_q && pop);
      wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = adv   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(store) - CW'(adv);
      full_d   = (cnt_d == CW'(DEPTH));
      empty_d  = (cnt_d == '0);
      rd_data  = empty_q ? wr_data : mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= wr_data;
   end

   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/hsci_rdbuf_arb.sv
// Single-port RAM arbiter: buffered decoder writes take priority over host reads.
// Define HSCI_ARB_STARVE_GUARD_EN to force a host read after STARVE_LIMIT blocked cycles.
module hsci_rdbuf_arb
   import hsci_pkg::*;
#(
   parameter int WFIFO_DEPTH  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                   hsci_pclk,
   input  logic                   rst,
   hsci_rdbuf_arb_if.slave        bus,
   input  logic                   clear_errors,
   output logic                   wfifo_ovf,
   output logic                   wfifo_empty,
   output logic [1:0]             arb_fsm
);

   if (WFIFO_DEPTH < 2 || WFIFO_DEPTH > 16 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0 ||
       STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_cfg
      $error("hsci_rdbuf_arb: WFIFO_DEPTH or STARVE_LIMIT out of range");
   end

   arb_state_e   state_q, state_d;
   logic         ram_en_q, ram_en_d, gnt_q, gnt_d, ovf_q, ovf_d;
   we_t          ram_we_q, ram_we_d;
   addr_t        ram_addr_q, ram_addr_d;
   data_t        ram_wdata_q, ram_wdata_d, rdata_q, rdata_d;
   logic [1:0]   rd_vld_q, rd_vld_d;
   logic         push, pop, fifo_full, fifo_empty, fifo_avail, host_ok, force_rd;
   wfifo_entry_t push_ent, fifo_rd;

   assign push       = bus.dec_en && (bus.dec_we != '0);
   assign push_ent   = '{we: bus.dec_we, addr: bus.dec_addr, data: bus.dec_data};
   assign fifo_avail = !fifo_empty || push;
   // The grant cycle itself acknowledges the level request; req still high afterwards is a new one.
   assign host_ok    = bus.host_req && !gnt_q;

   hsci_arb_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
      .clk     (hsci_pclk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (push_ent),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef HSCI_ARB_STARVE_GUARD_EN
   logic [7:0] starve_q, starve_d;

   assign force_rd = host_ok && (int'(starve_q) >= STARVE_LIMIT - 1);

   always_comb begin
      starve_d = starve_q;
      if (gnt_q)                                  starve_d = '0;
      else if (bus.host_req && starve_q != 8'hFF) starve_d = starve_q + 8'd1;
   end

   always_ff @(posedge hsci_pclk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign force_rd = 1'b0;
`endif

   always_comb begin
      state_d     = ARB_IDLE;
      pop         = 1'b0;
      ram_en_d    = 1'b0;
      ram_we_d    = '0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      gnt_d       = 1'b0;
      if (force_rd) begin
         state_d    = ARB_FORCE;
         ram_en_d   = 1'b1;
         ram_addr_d = bus.host_addr;
         gnt_d      = 1'b1;
      end else if (fifo_avail) begin
         state_d     = ARB_WR;
         pop         = 1'b1;
         ram_en_d    = 1'b1;
         ram_we_d    = fifo_rd.we;
         ram_addr_d  = fifo_rd.addr;
         ram_wdata_d = fifo_rd.data;
      end else if (host_ok) begin
         state_d    = ARB_RD;
         ram_en_d   = 1'b1;
         ram_addr_d = bus.host_addr;
         gnt_d      = 1'b1;
      end
   end

   // Read return: RAM data lands the cycle after the grant and is registered once more.
   always_comb begin
      rd_vld_d = {rd_vld_q[0], gnt_q};
      rdata_d  = rd_vld_q[0] ? bus.ram_rdata : rdata_q;
      ovf_d    = ovf_q;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
      else if (clear_errors)         ovf_d = 1'b0;
   end

   always_ff @(posedge hsci_pclk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         ram_en_q    <= 1'b0;
         ram_we_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         gnt_q       <= 1'b0;
         rd_vld_q    <= '0;
         rdata_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         gnt_q       <= gnt_d;
         rd_vld_q    <= rd_vld_d;
         rdata_q     <= rdata_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.ram_en      = ram_en_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.host_gnt    = gnt_q;
   assign bus.host_rvalid = rd_vld_q[1];
   assign bus.host_rdata  = rdata_q;
   assign wfifo_ovf       = ovf_q;
   assign wfifo_empty     = fifo_empty && (state_q != ARB_WR);
   assign arb_fsm         = state_q;

endmodule

// File: tb/tb_hsci_rdbuf_arb.sv
// Bench for hsci_rdbuf_arb: per-cycle vector table plus multi-cycle sequences,
// with queues tracking expected RAM writes and host read returns.
module tb_hsci_rdbuf_arb;

   logic       hsci_pclk;
   logic       rst;
   logic       clear_errors;
   logic       wfifo_ovf;
   logic       wfifo_empty;
   logic [1:0] arb_fsm;

   hsci_rdbuf_arb_if bus ();

   hsci_rdbuf_arb #(.WFIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .hsci_pclk    (hsci_pclk),
      .rst          (rst),
      .bus          (bus),
      .clear_errors (clear_errors),
      .wfifo_ovf    (wfifo_ovf),
      .wfifo_empty  (wfifo_empty),
      .arb_fsm      (arb_fsm)
   );

   initial hsci_pclk = 1'b0;
   always #5 hsci_pclk = ~hsci_pclk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit sb_wr_en = 1'b1;

   typedef struct {
      logic [31:0] d;
      int          c;
   } rd_exp_t;

   rd_exp_t     exp_rd [$];
   logic [50:0] exp_wr [$];
   rd_exp_t     e_rd;
   logic [50:0] e_wr;

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [14:0] addr;
      logic [31:0] data;
      logic        req;
      logic [14:0] haddr;
      logic [1:0]  fsm;
      logic        ren;
      logic [3:0]  rwe;
      logic [14:0] raddr;
      logic        gnt;
      logic        emp;
      logic        rv;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   function automatic logic [31:0] model(input logic [14:0] a);
      return 32'hDEADBEEF ^ {17'd0, a ^ 15'd3};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hsci_pclk);
      #1;
   endtask

   task automatic drive_push(input logic en, input logic [3:0] we, input logic [14:0] a,
                             input logic [31:0] d);
      bus.dec_en   = en;
      bus.dec_we   = we;
      bus.dec_addr = a;
      bus.dec_data = d;
      if (en && we != 4'h0 && sb_wr_en) exp_wr.push_back({we, a, d});
   endtask

   // Synchronous RAM model: read data valid the cycle after the command.
   always @(posedge hsci_pclk or posedge rst) begin
      if (rst) bus.ram_rdata <= 32'h0;
      else if (bus.ram_en && bus.ram_we == 4'h0) bus.ram_rdata <= model(bus.ram_addr);
   end

   always @(posedge hsci_pclk) cyc <= cyc + 1;

   always @(negedge hsci_pclk) begin
      if (!rst) begin
         if (bus.ram_en && bus.ram_we != 4'h0 && sb_wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", bus.ram_en, 0);
            else begin
               e_wr = exp_wr.pop_front();
               check("wr_cmd", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, e_wr);
            end
         end
         if (bus.host_rvalid) begin
            if (exp_rd.size() == 0) check("rvalid_unexpected", bus.host_rvalid, 0);
            else begin
               e_rd = exp_rd.pop_front();
               check("rdata", bus.host_rdata, e_rd.d);
               check("rvalid_latency", cyc - e_rd.c, 2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gnt_k;
      int k;
      rst = 1'b1;
      clear_errors = 1'b0;
      bus.host_req = 1'b0;
      bus.host_addr = '0;
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);

      tbl[0]  = '{1'b1, 4'h1, 15'h0010, 32'h000000A5, 1'b0, 15'h0000, 2'd1, 1'b1, 4'h1, 15'h0010, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b0, 15'h0000, 2'd0, 1'b0, 4'h0, 15'h0010, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b1, 15'h0003, 2'd2, 1'b1, 4'h0, 15'h0003, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b0, 15'h0003, 2'd0, 1'b0, 4'h0, 15'h0003, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 4'h0, 15'h0055, 32'h0000FFFF, 1'b0, 15'h0003, 2'd0, 1'b0, 4'h0, 15'h0003, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 4'hF, 15'h0020, 32'h00000001, 1'b1, 15'h0007, 2'd1, 1'b1, 4'hF, 15'h0020, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 4'h2, 15'h0021, 32'h00000002, 1'b1, 15'h0007, 2'd1, 1'b1, 4'h2, 15'h0021, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b1, 15'h0007, 2'd2, 1'b1, 4'h0, 15'h0007, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b1, 15'h0007, 2'd0, 1'b0, 4'h0, 15'h0007, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b1, 15'h0007, 2'd2, 1'b1, 4'h0, 15'h0007, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b0, 15'h0007, 2'd0, 1'b0, 4'h0, 15'h0007, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 4'h0, 15'h0000, 32'h00000000, 1'b0, 15'h0007, 2'd0, 1'b0, 4'h0, 15'h0007, 1'b0, 1'b1, 1'b1};

      repeat (3) tick();
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_wdata", bus.ram_wdata, 0);
      check("rst_gnt", bus.host_gnt, 0);
      check("rst_rvalid", bus.host_rvalid, 0);
      check("rst_rdata", bus.host_rdata, 0);
      check("rst_ovf", wfifo_ovf, 0);
      check("rst_empty", wfifo_empty, 1);
      check("rst_fsm", arb_fsm, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive_push(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].data);
         bus.host_req  = tbl[i].req;
         bus.host_addr = tbl[i].haddr;
         tick();
         check($sformatf("v%0d fsm", i), arb_fsm, tbl[i].fsm);
         check($sformatf("v%0d ram_en", i), bus.ram_en, tbl[i].ren);
         check($sformatf("v%0d ram_we", i), bus.ram_we, tbl[i].rwe);
         check($sformatf("v%0d ram_addr", i), bus.ram_addr, tbl[i].raddr);
         check($sformatf("v%0d gnt", i), bus.host_gnt, tbl[i].gnt);
         check($sformatf("v%0d wfifo_empty", i), wfifo_empty, tbl[i].emp);
         check($sformatf("v%0d rvalid", i), bus.host_rvalid, tbl[i].rv);
         if (tbl[i].gnt) exp_rd.push_back('{model(tbl[i].haddr), cyc});
      end
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);
      bus.host_req = 1'b0;

      // Five back-to-back pushes with the host idle: all written, no overflow.
      for (int i = 0; i < 5; i++) begin
         drive_push(1'b1, 4'h3, 15'h0100 + 15'(i), 32'h00001000 + 32'(i));
         tick();
      end
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);
      repeat (2) tick();
      check("burst_drained", exp_wr.size(), 0);
      check("burst_ovf", wfifo_ovf, 0);
      check("burst_empty", wfifo_empty, 1);

      // Host blocked by continuous pushes.
      bus.host_req  = 1'b1;
      bus.host_addr = 15'h0AAA;
      gnt_k = 0;
      for (int i = 1; i <= 20; i++) begin
         drive_push(1'b1, 4'h5, 15'h0300 + 15'(i), 32'hC0DE0000 + 32'(i));
         tick();
         if (bus.host_gnt) begin
            gnt_k = i;
            exp_rd.push_back('{model(bus.host_addr), cyc});
            break;
         end
      end
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);
`ifdef HSCI_ARB_STARVE_GUARD_EN
      check("starve_blocked_cycles", gnt_k, 8);
      bus.host_req = 1'b0;
`else
      check("no_grant_while_writes", gnt_k, 0);
      tick();
      check("grant_after_drain", bus.host_gnt, 1);
      if (bus.host_gnt) exp_rd.push_back('{model(bus.host_addr), cyc});
      bus.host_req = 1'b0;
`endif
      repeat (4) tick();
      check("starve_wr_drained", exp_wr.size(), 0);

`ifdef HSCI_ARB_STARVE_GUARD_EN
      // Forced reads stall pops; sustained pushes eventually overflow.
      sb_wr_en = 1'b0;
      bus.host_req = 1'b1;
      k = 0;
      for (int i = 0; i < 150; i++) begin
         drive_push(1'b1, 4'h1, 15'h0400, 32'h0);
         tick();
         if (bus.host_gnt) exp_rd.push_back('{model(bus.host_addr), cyc});
         if (wfifo_ovf) begin
            k = 1;
            break;
         end
      end
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);
      bus.host_req = 1'b0;
      check("ovf_set", k, 1);
      for (int i = 0; i < 20 && !wfifo_empty; i++) tick();
      check("ovf_drain_empty", wfifo_empty, 1);
      check("ovf_sticky", wfifo_ovf, 1);
      repeat (4) tick();
      exp_wr.delete();
      sb_wr_en = 1'b1;
`endif
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check("ovf_cleared", wfifo_ovf, 0);

      // Reset one cycle after a grant discards the in-flight read and buffered write.
      bus.host_req  = 1'b1;
      bus.host_addr = 15'h0009;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.host_gnt) begin
            k = 1;
            break;
         end
      end
      check("rst_seq_grant", k, 1);
      bus.host_req = 1'b0;
      sb_wr_en = 1'b0;
      drive_push(1'b1, 4'h1, 15'h0200, 32'h12345678);
      tick();
      rst = 1'b1;
      drive_push(1'b0, 4'h0, 15'h0, 32'h0);
      exp_rd.delete();
      exp_wr.delete();
      sb_wr_en = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("post_rst_quiet%0d", i), {bus.ram_en, bus.host_rvalid, bus.host_gnt}, 0);
      end
      check("post_rst_empty", wfifo_empty, 1);
      check("post_rst_fsm", arb_fsm, 0);

      check("rd_queue_empty", exp_rd.size(), 0);
      check("wr_queue_empty", exp_wr.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
